// File: rtl/cpu_dbg_ctrl_if.sv
// Debug-port bundle between the board/UART debug front end (master) and the
// run-control sequencer (slave): a command channel and a register-dump stream.
//
// Handshake: both channels are valid/ready. A beat transfers on a rising clock
// edge where valid & ready are both high. The producer holds its payload
// stable while valid is high and ready is low. valid never waits on ready.
interface cpu_dbg_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, dump_ready,
        input  cmd_ready, dump_valid, dump_idx, dump_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, dump_ready,
        output cmd_ready, dump_valid, dump_idx, dump_data
    );
endinterface

// File: rtl/cpu_dbg_ctrl.sv
// Run-control and debug sequencer for the single-cycle MIPS core: gates core
// state updates through cpu_en, implements halt/run/single-step, one PC
// breakpoint, an executed-instruction counter and a 32-GPR dump stream.
module cpu_dbg_ctrl #(
    parameter bit RUN_ON_RESET = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    cpu_dbg_ctrl_if.slave    dbg,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_data,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    localparam logic [2:0] OP_HALT    = 3'd1;
    localparam logic [2:0] OP_RUN     = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_DUMP    = 3'd4;
    localparam logic [2:0] OP_SET_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_BP  = 3'd6;
    localparam logic [2:0] OP_CLR_CNT = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            state_q, state_d;
    logic              bp_en_q, bp_en_d;
    logic [31:0]       bp_addr_q, bp_addr_d;
    logic              bp_hit_q, bp_hit_d;
    logic              skip_q, skip_d;
    logic [4:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cmd_acc;
    logic              bp_match;
    logic              in_run;
    logic              in_step;
    logic              in_dump;

    // Decode of the current state and the breakpoint comparator.
    always_comb begin
        in_run   = (state_q == ST_RUN);
        in_step  = (state_q == ST_STEP);
        in_dump  = (state_q == ST_DUMP);
        bp_match = bp_en_q & (pc == bp_addr_q) & ~skip_q;
        cpu_en   = (in_run & ~bp_match) | in_step;
        dbg.cmd_ready  = (state_q == ST_RUN) | (state_q == ST_HALT);
        cmd_acc        = dbg.cmd_valid & dbg.cmd_ready;
        dbg.dump_valid = in_dump;
        dbg.dump_idx   = idx_q;
        dbg.dump_data  = in_dump ? reg_data : 32'h0;
        reg_sel        = in_dump ? idx_q : 5'd0;
        halted         = (state_q == ST_HALT);
        bp_hit         = bp_hit_q;
        instr_cnt      = cnt_q;
        dbg_state      = state_q;
    end

    // Next-state logic: run control, breakpoint bookkeeping, dump walk, counter.
    always_comb begin
        state_d   = state_q;
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        bp_hit_d  = bp_hit_q;
        skip_d    = skip_q;
        idx_d     = idx_q;
        cnt_d     = cpu_en ? (cnt_q + CNT_ONE) : cnt_q;

        // The first executed instruction moves the PC off the breakpoint.
        if (cpu_en) begin
            skip_d = 1'b0;
        end

        // Breakpoint and counter commands are state-independent.
        if (cmd_acc) begin
            case (dbg.cmd_op)
                OP_SET_BP: begin
                    bp_addr_d = dbg.cmd_arg;
                    bp_en_d   = 1'b1;
                end
                OP_CLR_BP:  bp_en_d = 1'b0;
                OP_CLR_CNT: cnt_d   = '0;
                default: ;
            endcase
        end

        case (state_q)
            ST_RUN: begin
                if (bp_match) begin
                    state_d  = ST_HALT;
                    bp_hit_d = 1'b1;
                end else if (cmd_acc && dbg.cmd_op == OP_HALT) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (cmd_acc) begin
                    case (dbg.cmd_op)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            bp_hit_d = 1'b0;
                            skip_d   = 1'b1;
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            bp_hit_d = 1'b0;
                            skip_d   = 1'b1;
                        end
                        OP_DUMP: begin
                            state_d = ST_DUMP;
                            idx_d   = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: state_d = ST_HALT;
            ST_DUMP: begin
                if (dbg.dump_ready) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // State registers; reset aborts any step or dump in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN_ON_RESET ? ST_RUN : ST_HALT;
            bp_en_q   <= 1'b0;
            bp_addr_q <= 32'h0;
            bp_hit_q  <= 1'b0;
            skip_q    <= 1'b0;
            idx_q     <= 5'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
            bp_hit_q  <= bp_hit_d;
            skip_q    <= skip_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Bench for cpu_dbg_ctrl: a tiny behavioural core (PC + register file) sits
// beside the controller; expectations come from run-control arithmetic.
module tb_cpu_dbg_ctrl;
  localparam logic [2:0] OP_HALT    = 3'd1;
  localparam logic [2:0] OP_RUN     = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_DUMP    = 3'd4;
  localparam logic [2:0] OP_SET_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_BP  = 3'd6;
  localparam logic [2:0] OP_CLR_CNT = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with RUN_ON_RESET = 1 ----------------
  cpu_dbg_ctrl_if bus1 ();
  logic [31:0] core_pc;
  logic        cpu_en1;
  logic [4:0]  reg_sel1;
  logic [31:0] reg_data1;
  logic        halted1;
  logic        bp_hit1;
  logic [31:0] instr_cnt1;
  logic [1:0]  dbg_state1;
  logic [31:0] rf [32];

  cpu_dbg_ctrl #(.RUN_ON_RESET(1'b1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .dbg(bus1), .pc(core_pc), .cpu_en(cpu_en1),
    .reg_sel(reg_sel1), .reg_data(reg_data1), .halted(halted1),
    .bp_hit(bp_hit1), .instr_cnt(instr_cnt1), .dbg_state(dbg_state1)
  );

  // behavioural single-cycle core: PC advances by 4 per enabled cycle
  always @(posedge clk or posedge rst) begin
    if (rst) core_pc <= 32'h0;
    else if (cpu_en1) core_pc <= core_pc + 32'd4;
  end
  assign reg_data1 = rf[reg_sel1];

  // ---------------- DUT with RUN_ON_RESET = 0 ----------------
  cpu_dbg_ctrl_if bus0 ();
  logic [31:0] pc0;
  logic        cpu_en0;
  logic [4:0]  reg_sel0;
  logic [31:0] reg_data0;
  logic        halted0;
  logic        bp_hit0;
  logic [31:0] instr_cnt0;
  logic [1:0]  dbg_state0;

  cpu_dbg_ctrl #(.RUN_ON_RESET(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .dbg(bus0), .pc(pc0), .cpu_en(cpu_en0),
    .reg_sel(reg_sel0), .reg_data(reg_data0), .halted(halted0),
    .bp_hit(bp_hit0), .instr_cnt(instr_cnt0), .dbg_state(dbg_state0)
  );

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus1.cmd_valid  = 1'b0;
    bus1.dump_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    int w;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_op    = op;
    bus1.cmd_arg   = arg;
    w = 0;
    while (!bus1.cmd_ready && w < 50) begin
      step();
      w++;
    end
    if (w == 50) check("cmd_accept_timeout", 64'd0, 64'd1);
    step();
    bus1.cmd_valid = 1'b0;
    bus1.cmd_op    = 3'd0;
  endtask

  task automatic wait_halt(input string tag);
    int w;
    w = 0;
    while (!halted1 && w < 200) begin
      step();
      w++;
    end
    if (w == 200) check(tag, 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int k;
    int m;
    int w;
    int got_n;
    int cyc;
    logic [31:0] base_pc;
    logic [31:0] base_cnt;
    logic [31:0] cap [32];

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'd0; bus1.cmd_arg = 32'h0; bus1.dump_ready = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 3'd0; bus0.cmd_arg = 32'h0; bus0.dump_ready = 1'b0;
    pc0 = 32'h0;
    reg_data0 = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0]  = 32'h0;
    rf[1]  = 32'h0000_1234;
    rf[31] = 32'hFFFF_0000;

    // reset values for both parameterisations
    step();
    check("rst1_cpu_en", cpu_en1, 1);
    check("rst1_halted", halted1, 0);
    check("rst1_cnt", instr_cnt1, 0);
    check("rst1_dump_valid", bus1.dump_valid, 0);
    check("rst1_bp_hit", bp_hit1, 0);
    check("rst1_cmd_ready", bus1.cmd_ready, 1);
    check("rst0_cpu_en", cpu_en0, 0);
    check("rst0_halted", halted0, 1);
    rst = 1'b0;

    // free-running counter counts executed cycles
    n = $urandom_range(3, 10);
    for (int i = 1; i <= n; i++) begin
      step();
      check("run_cnt", instr_cnt1, i);
    end
    check("run_pc", core_pc, 4 * n);

    // halted-at-reset instance stays idle until told to run
    check("dut0_still_halted", halted0, 1);
    check("dut0_cnt_idle", instr_cnt0, 0);
    bus0.cmd_valid = 1'b1; bus0.cmd_op = OP_RUN;
    step();
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 3'd0;
    check("dut0_run_en", cpu_en0, 1);
    check("dut0_run_halted", halted0, 0);
    step();
    check("dut0_run_cnt", instr_cnt0, 1);

    // breakpoint at 0x10 while running from 0
    apply_reset();
    send_cmd(OP_SET_BP, 32'h0000_0010);
    wait_halt("bp10_timeout");
    check("bp10_pc", core_pc, 32'h10);
    check("bp10_hit", bp_hit1, 1);
    check("bp10_cnt", instr_cnt1, 4);
    check("bp10_cpu_en", cpu_en1, 0);
    repeat ($urandom_range(2, 5)) step();
    check("bp10_frozen_pc", core_pc, 32'h10);
    check("bp10_frozen_cnt", instr_cnt1, 4);
    send_cmd(OP_RUN, 32'h0);
    check("bp10_run_halted", halted1, 0);
    check("bp10_run_hit_clr", bp_hit1, 0);
    check("bp10_run_en", cpu_en1, 1);
    step();
    check("bp10_run_pc", core_pc, 32'h14);
    check("bp10_run_cnt", instr_cnt1, 5);

    // randomized breakpoint addresses
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      k = $urandom_range(2, 20);
      send_cmd(OP_SET_BP, 32'(4 * k));
      wait_halt("bp_rand_timeout");
      check("bp_rand_pc", core_pc, 4 * k);
      check("bp_rand_cnt", instr_cnt1, k);
      check("bp_rand_hit", bp_hit1, 1);
    end

    // run, then HALT: the accept cycle still executes
    send_cmd(OP_RUN, 32'h0);
    m = $urandom_range(1, 5);
    repeat (m) step();
    send_cmd(OP_HALT, 32'h0);
    check("halt_halted", halted1, 1);
    check("halt_pc", core_pc, 4 * k + 4 * m + 4);
    check("halt_cnt", instr_cnt1, k + m + 1);
    check("halt_cpu_en", cpu_en1, 0);
    repeat (3) step();
    check("halt_frozen_pc", core_pc, 4 * k + 4 * m + 4);

    // three single steps
    base_pc  = 32'(4 * k + 4 * m + 4);
    base_cnt = 32'(k + m + 1);
    for (int s = 0; s < 3; s++) begin
      repeat ($urandom_range(0, 3)) step();
      send_cmd(OP_STEP, 32'h0);
      check("step_cpu_en", cpu_en1, 1);
      check("step_cmd_ready", bus1.cmd_ready, 0);
      check("step_halted", halted1, 0);
      step();
      check("step_back_halted", halted1, 1);
      check("step_back_en", cpu_en1, 0);
    end
    check("step_pc", core_pc, base_pc + 32'd12);
    check("step_cnt", instr_cnt1, base_cnt + 32'd3);

    // register dump with ready toggling
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(rf[i]);
    send_cmd(OP_DUMP, 32'h0);
    got_n = 0;
    cyc = 0;
    while (got_n < 32 && cyc < 200) begin
      bus1.dump_ready = (cyc % 2 == 1) || ($urandom_range(0, 3) == 0);
      #1;
      check("dump_valid", bus1.dump_valid, 1);
      check("dump_idx", bus1.dump_idx, got_n);
      check("dump_data", bus1.dump_data, exp_q[0]);
      if (bus1.dump_ready) begin
        cap[got_n] = bus1.dump_data;
        void'(exp_q.pop_front());
        got_n++;
      end
      step();
      cyc++;
    end
    bus1.dump_ready = 1'b0;
    check("dump_count", got_n, 32);
    check("dump_r1", cap[1], 32'h0000_1234);
    check("dump_r31", cap[31], 32'hFFFF_0000);
    check("dump_end_halted", halted1, 1);
    check("dump_end_valid", bus1.dump_valid, 0);
    check("dump_end_reg_sel", reg_sel1, 0);
    check("dump_end_pc", core_pc, base_pc + 32'd12);

    // HALT accepted in the same cycle the breakpoint matches
    apply_reset();
    k = $urandom_range(3, 15);
    send_cmd(OP_SET_BP, 32'(4 * k));
    w = 0;
    while (core_pc != 32'(4 * k) && w < 100) begin
      step();
      w++;
    end
    check("bphalt_reach", core_pc, 4 * k);
    check("bphalt_match_en", cpu_en1, 0);
    bus1.cmd_valid = 1'b1; bus1.cmd_op = OP_HALT;
    step();
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'd0;
    check("bphalt_halted", halted1, 1);
    check("bphalt_hit", bp_hit1, 1);
    check("bphalt_cnt", instr_cnt1, k);
    step();
    check("bphalt_pc", core_pc, 4 * k);

    // cleared breakpoint is never taken
    send_cmd(OP_RUN, 32'h0);
    send_cmd(OP_SET_BP, 32'(4 * k + 40));
    send_cmd(OP_CLR_BP, 32'h0);
    repeat (20) step();
    check("clrbp_halted", halted1, 0);
    check("clrbp_pc", core_pc, 4 * k + 88);

    // CLR_CNT wins over the same-cycle increment
    send_cmd(OP_CLR_CNT, 32'h0);
    check("clrcnt_zero", instr_cnt1, 0);
    step();
    check("clrcnt_one", instr_cnt1, 1);

    // reset in the middle of a dump
    send_cmd(OP_HALT, 32'h0);
    send_cmd(OP_DUMP, 32'h0);
    bus1.dump_ready = 1'b1;
    w = 0;
    while (bus1.dump_idx != 5'd7 && w < 50) begin
      step();
      w++;
    end
    check("mid_dump_idx", bus1.dump_idx, 7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus1.dump_valid, 0);
    check("mid_rst_halted", halted1, 0);
    check("mid_rst_en", cpu_en1, 1);
    check("mid_rst_cnt", instr_cnt1, 0);
    check("mid_rst_reg_sel", reg_sel1, 0);
    check("mid_rst_cmd_ready", bus1.cmd_ready, 1);
    step();
    rst = 1'b0;
    bus1.dump_ready = 1'b0;
    step();
    step();
    check("post_rst_cnt", instr_cnt1, 2);
    check("post_rst_valid", bus1.dump_valid, 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_dbg_ctrl.md
# cpu_dbg_ctrl

Run-control and debug sequencer for the single-cycle MIPS core.
- Gates the core's architectural state updates (PC, register file, data memory write) through one enable.
- Supports halt, run and single-step from a command port, plus one PC breakpoint.
- Walks the register-file debug read port (`reg_sel`/`reg_data`) to stream all 32 GPRs out on a valid/ready port.
- Sits beside the core in the top level, between the board/UART debug front end and the CPU.

## Interface
Parameters:
- `RUN_ON_RESET`, 1: state after reset. 1 = RUN, 0 = HALT.
- `CNT_W`, 32: width of the executed-instruction counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command strobe.
- `cmd_ready` out 1: a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_op` in 3: 0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 DUMP, 5 SET_BP, 6 CLR_BP, 7 CLR_CNT.
- `cmd_arg` in 32: breakpoint address for SET_BP.
- `pc` in 32: core PC.
- `cpu_en` out 1: core enable. The top level ANDs it into PC load, RF write and MemWrite.
- `reg_sel` out 5: RF debug select.
- `reg_data` in 32: RF debug data (combinational from `reg_sel`).
- `dump_valid` out 1, `dump_ready` in 1, `dump_idx` out 5, `dump_data` out 32: register dump stream.
- `halted` out 1: state is HALT.
- `bp_hit` out 1: sticky flag, breakpoint caused the halt.
- `instr_cnt` out CNT_W: count of cycles with `cpu_en`=1.

## Operation
States: HALT, RUN, STEP, DUMP.

Combinational signals:
- `bp_match` = `bp_en & (pc == bp_addr) & ~skip`.
- `cpu_en` = (RUN & ~`bp_match`) | STEP.

Transitions:
- RUN: `bp_match` -> HALT and set `bp_hit`; this has priority over any command that cycle. Accepted HALT -> HALT (the accept cycle still executes). STEP and DUMP are accepted and ignored.
- HALT: RUN -> RUN, STEP -> STEP, DUMP -> DUMP (idx=0). HALT is a no-op. RUN and STEP clear `bp_hit` and set `skip`.
- STEP: exactly one cycle with `cpu_en`=1, then HALT.
- DUMP: `reg_sel`=`dump_idx`=idx, `dump_data`=`reg_data`, `dump_valid`=1. On `dump_valid & dump_ready`: idx+1; after the transfer of idx 31, go to HALT.

Other command behaviour:
- `skip` clears on the first cycle with `cpu_en`=1. This lets RUN/STEP leave a breakpoint PC without re-hitting it.
- SET_BP: `bp_addr`<=`cmd_arg`, `bp_en`<=1. CLR_BP: `bp_en`<=0. Both are legal in RUN and HALT.
- CLR_CNT: `instr_cnt`<=0. It wins over a same-cycle increment.
- `cmd_ready`=1 in RUN and HALT, 0 in STEP and DUMP.
- Outside DUMP, `reg_sel` is driven from an external-free default of 0.

## Timing
Reset values:
- state = RUN if `RUN_ON_RESET`, else HALT.
- `bp_en`=0, `bp_addr`=0, `bp_hit`=0, `skip`=0, idx=0, `instr_cnt`=0.
- `dump_valid`=0; `halted` and `cpu_en` follow the reset state.

Latencies:
- HALT command: core stops on the cycle after acceptance.
- RUN/STEP command: `cpu_en`=1 from the cycle after acceptance.
- Breakpoint: same-cycle. The instruction at `bp_addr` does not execute; `halted`=1 from the next cycle.

Counter and dump:
- `instr_cnt` wraps modulo 2^CNT_W.
- Dump takes at least 32 cycles, one per handshake. `dump_data` must be stable while `dump_valid` & ~`dump_ready` (guaranteed because the core is frozen).

Reset mid-operation:
- Reset mid-DUMP or mid-STEP aborts immediately to the reset state.
- No partial handshakes persist.

## Test plan
- Reset with `RUN_ON_RESET`=1 -> `cpu_en`=1, `halted`=0, `instr_cnt` increments 0,1,2…; with 0 -> `cpu_en`=0, `halted`=1.
- SET_BP 0x0000_0010 while running from 0 -> halt with `pc`=0x10, `bp_hit`=1, `instr_cnt`=4; then RUN -> `pc` advances to 0x14, `bp_hit`=0.
- In HALT, three STEP commands -> exactly 3 cycles of `cpu_en`, `pc` +12, `cmd_ready` low during each step cycle.
- DUMP after loading $1=0x1234, $31=0xFFFF_0000, with `dump_ready` toggling 1/0 -> 32 transfers in idx order, $1 and $31 values correct, data held while ready=0, then HALT.
- HALT accepted in the same cycle `bp_match` is true -> single transition to HALT, `bp_hit`=1, no extra instruction executed.
- Assert `rst` at dump idx 7 -> `dump_valid`=0 immediately, state per `RUN_ON_RESET`, `instr_cnt`=0; CLR_CNT during RUN -> `instr_cnt`=0 next cycle.
